// File: rtl/ex_mdu_pkg.sv
// Shared MDU opcodes, default latencies and op-class helpers.
// MDU_MADD_EN enables the multiply-accumulate op class.
package ex_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  function automatic logic is_div(
    input logic [3:0] op
  );
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_long(
    input logic [3:0] op
  );
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU)
      || is_div(op);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU)
      || (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return r;
  endfunction

endpackage

// File: rtl/ex_mdu_arith.sv
// Combinational MDU datapath: {hi,lo} result from op, operands, HI/LO.
// MDU_MADD_EN adds the accumulate/subtract forms.
module ex_mdu_arith
  import ex_mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [63:0] acc;

  assign acc   = {hi, lo};
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes, then restore signs (trunc toward zero)
  always_comb begin
    abs_a = a[31] ? -a : a;
    abs_b = b[31] ? -b : b;
    sq = abs_a / abs_b;
    sr = abs_a % abs_b;
    if (a[31] ^ b[31]) sq = -sq;
    if (a[31]) sr = -sr;
    uq = a / b;
    ur = a % b;
  end

  // Result select; divide by zero leaves HI/LO as they were
  always_comb begin
    res = acc;
    case (op)
      MDU_MULT:  res = sprod;
      MDU_MULTU: res = uprod;
      MDU_DIV:   res = (b == 32'd0) ? acc : {sr, sq};
      MDU_DIVU:  res = (b == 32'd0) ? acc : {ur, uq};
`ifdef MDU_MADD_EN
      MDU_MADD:  res = acc + sprod;
      MDU_MADDU: res = acc + uprod;
      MDU_MSUB:  res = acc - sprod;
      MDU_MSUBU: res = acc - uprod;
`endif
      default:   res = acc;
    endcase
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multi-cycle multiply/divide unit holding HI/LO.
// MDU_MADD_EN enables madd/maddu/msub/msubu.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ErrSignal,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [7:0]  cnt_q;
  logic [63:0] res_q;
  logic [63:0] res_c;
  logic        accept;
  logic        mt_ok;
  logic        commit;

  ex_mdu_arith u_arith (
    .op  (MDUOp),
    .a   (A),
    .b   (B),
    .hi  (HI),
    .lo  (LO),
    .res (res_c)
  );

  assign mt_ok  = (state_q == S_IDLE)
                & Start & ~ErrSignal;
  assign accept = mt_ok & is_long(MDUOp);
  assign Stall  = Busy | (Start & is_long(MDUOp));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == S_IDLE): if (accept) state_d = S_RUN;
      (state_q == S_RUN):  if (cnt_q == 8'd1) state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    Busy   = (state_q == S_RUN);
    commit = (state_q == S_RUN) && (cnt_q == 8'd1);
  end

  // Counter, hidden result and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 8'd0;
      res_q <= 64'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else if (accept) begin
      res_q <= res_c;
      cnt_q <= is_div(MDUOp) ? 8'(DIV_CYCLES)
                             : 8'(MULT_CYCLES);
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q - 8'd1;
      if (commit) begin
        HI <= res_q[63:32];
        LO <= res_q[31:0];
      end
    end else if (mt_ok) begin
      if (MDUOp == MDU_MTHI) HI <= A;
      if (MDUOp == MDU_MTLO) LO <= A;
    end
  end

`ifndef SYNTHESIS
  // The hazard unit must hold MDU ops back while an op is in flight
  no_start_in_run: assert property (
    @(posedge clk) disable iff (!reset)
    !(state_q == S_RUN && Start && MDUOp != MDU_NONE)
  );
`endif

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multi-cycle multiply/divide unit inside the EX stage, directly upstream of the Mem stage.
- Executes mult/multu/div/divu and mthi/mtlo, and holds the architectural HI/LO registers.
- EX muxes HI/LO into the ALU result path for mfhi/mflo, which then travels to Mem as ALUOut_EX_to_Mem.
- Provides a busy/stall indication to the hazard unit.

Parameters:
- MULT_CYCLES, 5, cycles from accepted start to HI/LO update for multiply ops.
- DIV_CYCLES, 10, cycles from accepted start to HI/LO update for divide ops.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- Start  input  1  EX instruction is an MDU op this cycle (pulse; one cycle per instruction).
- MDUOp  input  4  operation code (encoding in shared package).
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- ErrSignal  input  1  exception/flush pending from Mem; the EX instruction must not commit.
- Busy  output  1  operation in flight.
- Stall  output  1  Busy | (Start & op is multiply/divide); the hazard unit stalls MDU ops and mfhi/mflo while this is high.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

Behaviour:
- One clock domain (clk). reset is synchronous and active-low.
- While reset==0 at a clock edge, all of the following clear to 0: HI, LO, Busy, the cycle counter, and the internal result registers. The state machine goes to IDLE.
- The state machine has two states, IDLE and RUN.
- IDLE, Start=1, ErrSignal=0, op in {mult,multu,div,divu}:
  - At the edge, latch A and B and compute the result into hidden registers (64-bit product; for divides, quotient to LO and remainder to HI).
  - Load counter = MULT_CYCLES or DIV_CYCLES, set Busy=1, go to RUN.
- RUN: the counter decrements each cycle. At the edge where the counter goes from 1 to 0:
  - HI/LO take the hidden result and Busy drops to 0.
  - HI/LO are therefore visible exactly N cycles after the start edge.
- mthi/mtlo, accepted only in IDLE with ErrSignal=0: HI<=A (or LO<=A) at the edge. Busy stays 0, latency 1.
- Signed ops use two's complement. mult produces a 64-bit signed product; div truncates toward zero and the remainder takes the sign of the dividend. Unsigned ops are zero-extended.
- Divide by zero (B==0): the op still runs DIV_CYCLES with Busy high, and HI/LO keep their previous values.
- Start with ErrSignal=1: ignored, no state change.
- ErrSignal during RUN: no effect. The in-flight op belongs to an already-committed instruction and completes normally.
- Start while in RUN: ignored. The hazard unit guarantees this does not happen; a simulation-only assertion flags it.
- MDUOp=NONE or an undefined code with Start=1: no effect.
- reset==0 mid-RUN: the op is aborted and HI/LO are cleared.
- Stall is combinational. HI and LO are registered outputs.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops madd/maddu/msub/msubu are enabled. The unit computes {HI,LO} ± A*B (signed or unsigned per op) and commits after MULT_CYCLES like mult. The accumulator base is the HI/LO value at the start edge.
- Undefined: those codes behave as NONE (no state change, Busy stays 0).

Decomposition:
- Shared package (CPU_Param.v) holds:
  - MDUOp codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - Default latency constants.
- One sub-module, mdu_arith: purely combinational. It computes the 64-bit {hi,lo} result from op, A, B and the current {HI,LO}, and keeps the signed/unsigned and divide-by-zero rules in one place.
- The FSM, counter and HI/LO registers live in ex_mdu.

Test Plan:
- Reset, then mult with A=0xFFFFFFFE (-2), B=3:
  - Busy is high for 5 cycles; HI/LO stay 0 until then.
  - Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- divu A=7, B=2 → after 10 cycles HI=1, LO=3. Then div A=0xFFFFFFF9 (-7), B=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- Divide by zero: set HI=0x11/LO=0x22 via mthi/mtlo, then div A=5, B=0 → Busy for 10 cycles, HI/LO still 0x11/0x22.
- Start=1 together with ErrSignal=1 on multu A=B=0xFFFFFFFF → Busy stays 0, HI/LO unchanged. Repeat with ErrSignal=0 → HI=0xFFFFFFFE, LO=0x00000001.
- Start mult, pull reset low at RUN cycle 3 → next edge Busy=0, HI=LO=0. Release reset, then mtlo A=0xABCD → LO=0xABCD after 1 cycle.
- MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 → HI=1, LO=0 after 5 cycles. Undefined: the same stimulus leaves HI/LO unchanged and Busy=0.
